regfile_fib_sequencer: RTL and testbench
========================================

// Module: regfile_fib_sequencer
// PURPOSE
//  Parametrised instruction sequencer that drives the datapath through a Fibonacci register-file sweep.
//  Sequence: ADDI 1 into r0 and r1, ADD r0+r1 into r1, then a MOV/ADD pair for each register r2..r(NUM_REGS-1).
//  Opcodes are generated algorithmically, not from a table.
//  Self-checks rout against an internally computed expected value after every ADDI/ADD, and supports run and single-step modes.
//  Sits between the test top-level (switches/buttons, 7-seg) and the datapath (opcode, cin in; flags, rout out).
// PARAMETERS
//  DATA_W     16  datapath/rout width; expected values wrap mod 2^DATA_W
//  NUM_REGS   16  registers swept, legal 3..16 (register fields are 4 bits)
//  CHECK_LAT  1   cycles from opcode issue to rout valid, legal 1..4
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low reset
//  start      in   1       1-cycle pulse; begins sweep from IDLE or DONE
//  step_mode  in   1       1 = advance only on step pulses; 0 = free-run
//  step       in   1       1-cycle pulse; advances one instruction when step_mode=1
//  flags      in   5       datapath flags; bit 3 = carry
//  rout       in   DATA_W  datapath result
//  opcode     out  16      instruction to datapath
//  op_valid   out  1       opcode is a new instruction this cycle
//  cin        out  1       registered flags[3]
//  state      out  3       FSM state encoding (below)
//  reg_idx    out  4       destination register of current opcode
//  busy       out  1       state not IDLE/DONE
//  done       out  1       high in DONE
//  err        out  1       sticky; any check mismatch this sweep
//  err_count  out  8       mismatch count, saturates at 255
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; opcode=16'h0000; op_valid, cin, busy, done, err=0; err_count=0; reg_idx=0; check pipe cleared. Reset mid-sweep aborts at once.
//  Encodings:
//   ADDI rd,1 = {4'b0101, rd, 8'h01}
//   ADD  rd+=rs = {4'b0000, rd, 4'b0101, rs}
//   MOV  rd<=rs = {4'b0000, rd, 4'b1101, rs}
//   NOP = MOV r(N-1)<=r(N-1)
//  States, in issue order:
//   IDLE(0)  opcode=NOP, op_valid=0
//   LD0(1)   ADDI r0; exp=1
//   LD1(2)   ADDI r1; exp=1
//   ADD1(3)  ADD r1+=r0; exp=2
//   MOV(4)   MOV rk<=r(k-1), k starts at 2
//   ADDK(5)  ADD rk+=r(k-2); exp=e(k-1)+e(k-2) mod 2^DATA_W
//   DONE(6)  opcode=NOP, op_valid=0, done=1
//  Transitions:
//   IDLE/DONE -> LD0 on start; err and err_count clear on that edge.
//   LD0 -> LD1 -> ADD1 -> MOV.
//   MOV -> ADDK.
//   ADDK -> MOV with k+1 if k<NUM_REGS-1; else DONE after CHECK_LAT drain cycles (busy=1 while draining).
//  Advance gate: free-run advances every cycle; step_mode advances only on cycles with step=1.
//   When not advancing, opcode holds NOP and op_valid=0; the sequence position is kept.
//  op_valid=1 only on the first cycle each instruction is presented.
//  Expected history: two registers e1 (last expected) and e2 (one before). After ADD1, e1=2 and e2=1. Results: r0=1, rk=F(k+2).
//  Check: each ADDI/ADD issue pushes {1, exp} into a CHECK_LAT-deep pipe. At pipe output, rout != exp sets err and increments err_count. MOV and NOP are not checked.
//  cin <= flags[3] every cycle, including IDLE.
//  start while busy: ignored. step while step_mode=0: ignored. start and step in the same cycle: start wins from IDLE/DONE.
//  Toggling step_mode mid-sweep takes effect on the next cycle; no instruction is skipped or repeated.
//  Total issued instructions = 3 + 2*(NUM_REGS-2).
// TESTING
//  1. NUM_REGS=16, DATA_W=16, free-run, datapath model:
//     start -> 31 op_valid pulses in order ADDI r0, ADDI r1, ADD r1+=r0, MOV r2<=r1, ADD r2+=r0, ..., ADD r15+=r13.
//     Last check rout=1597; done=1, err=0.
//  2. DATA_W=8: r12 result 377 wraps to 121 and sets flags[3] -> cin=1 on the next cycle.
//     r15 check value=61; err=0.
//  3. Datapath model corrupts the r7 result (+1) -> err=1, err_count=1, and the sweep still completes.
//     A new start clears err and err_count.
//  4. step_mode=1: exactly one op_valid per step pulse, opcode=NOP between pulses.
//     After 5 pulses reg_idx=2 and state=ADDK.
//  5. Pull reset low asynchronously mid-sweep at state MOV, k=9 -> outputs reach reset values before the next edge.
//     Release reset, start -> the sweep restarts at ADDI r0.
//  6. Pulse start while busy -> no effect. Pulse start in DONE -> the sweep reruns with identical opcode trace.

Source files
------------

// File: rtl/regfile_fib_sequencer_if.sv
// Datapath-facing bus of the Fibonacci sequencer: instructions go out, results and flags come back.
interface regfile_fib_sequencer_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       opcode;
    logic              op_valid;
    logic              cin;
    logic [4:0]        flags;
    logic [DATA_W-1:0] rout;

    modport master (output opcode, op_valid, cin, input flags, rout);
    modport slave  (input opcode, op_valid, cin, output flags, rout);
endinterface

// File: rtl/regfile_fib_sequencer.sv
// Issues the ADDI/ADD/MOV sweep that fills the register file with Fibonacci numbers
// and checks each arithmetic result against an internally tracked expected value.
module regfile_fib_sequencer #(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 16,
    parameter int CHECK_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    step_mode,
    input  logic                    step,
    regfile_fib_sequencer_if.master dp,
    output logic [2:0]              state,
    output logic [3:0]              reg_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [7:0]              err_count
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, LD0 = 3'd1, LD1 = 3'd2, ADD1 = 3'd3,
        MOV  = 3'd4, ADDK = 3'd5, DONE = 3'd6
    } state_t;

    localparam logic [3:0]  LAST_REG  = 4'(NUM_REGS - 1);
    localparam logic [15:0] NOP       = {4'b0000, LAST_REG, 4'b1101, LAST_REG};
    localparam logic [2:0]  DRAIN_END = 3'(CHECK_LAT);

    state_t            state_reg, state_next, issue_state;
    logic [3:0]        k_reg, k_next, issue_k;
    logic              issued_reg, issued_next;
    logic [2:0]        drain_reg, drain_next;
    logic [15:0]       opcode_reg, opcode_next;
    logic              op_valid_reg, op_valid_next;
    logic [3:0]        reg_idx_reg, reg_idx_next;
    logic [DATA_W-1:0] e1_reg, e1_next, e2_reg, e2_next;
    logic              cin_reg, err_reg;
    logic [7:0]        err_count_reg;
    logic              do_issue, push_valid, advance, restart, mismatch;
    logic [DATA_W-1:0] push_exp;
    logic              pipe_valid_reg [CHECK_LAT+1];
    logic [DATA_W-1:0] pipe_exp_reg   [CHECK_LAT+1];
    logic [3:0]        unused_flags;

    assign advance  = ~step_mode | step;
    assign restart  = start && (state_reg == IDLE || state_reg == DONE);
    assign mismatch = pipe_valid_reg[CHECK_LAT] && (dp.rout != pipe_exp_reg[CHECK_LAT]);
    assign unused_flags = {dp.flags[4], dp.flags[2:0]};

    // The state register names the instruction last presented; issued_reg=0 only
    // right after start, when LD0 is pending but has not yet been put on the bus.
    always_comb begin
        state_next    = state_reg;
        k_next        = k_reg;
        issued_next   = issued_reg;
        drain_next    = drain_reg;
        issue_state   = state_reg;
        issue_k       = k_reg;
        do_issue      = 1'b0;
        opcode_next   = NOP;
        op_valid_next = 1'b0;
        reg_idx_next  = reg_idx_reg;
        e1_next       = e1_reg;
        e2_next       = e2_reg;
        push_valid    = 1'b0;
        push_exp      = '0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next  = LD0;
                    k_next      = 4'd2;
                    issued_next = 1'b0;
                    drain_next  = 3'd0;
                end
            end
            default: begin
                if (state_reg == ADDK && k_reg == LAST_REG && issued_reg) begin
                    // Final ADD is out: wait for its check to leave the pipe, regardless of stepping.
                    if (drain_reg == DRAIN_END) state_next = DONE;
                    else                        drain_next = drain_reg + 3'd1;
                end else if (advance) begin
                    do_issue    = 1'b1;
                    issued_next = 1'b1;
                    if (issued_reg) begin
                        case (state_reg)
                            LD0:     issue_state = LD1;
                            LD1:     issue_state = ADD1;
                            ADD1:    begin issue_state = MOV; issue_k = 4'd2; end
                            MOV:     issue_state = ADDK;
                            default: begin issue_state = MOV; issue_k = k_reg + 4'd1; end
                        endcase
                    end
                    state_next = issue_state;
                    k_next     = issue_k;
                end
            end
        endcase

        if (do_issue) begin
            op_valid_next = 1'b1;
            case (issue_state)
                LD0: begin
                    opcode_next = {4'b0101, 4'd0, 8'h01};
                    reg_idx_next = 4'd0;
                    push_valid = 1'b1;
                    push_exp   = DATA_W'(1);
                end
                LD1: begin
                    opcode_next = {4'b0101, 4'd1, 8'h01};
                    reg_idx_next = 4'd1;
                    push_valid = 1'b1;
                    push_exp   = DATA_W'(1);
                end
                ADD1: begin
                    opcode_next = {4'b0000, 4'd1, 4'b0101, 4'd0};
                    reg_idx_next = 4'd1;
                    push_valid = 1'b1;
                    push_exp   = DATA_W'(2);
                    e1_next    = DATA_W'(2);
                    e2_next    = DATA_W'(1);
                end
                MOV: begin
                    opcode_next = {4'b0000, issue_k, 4'b1101, issue_k - 4'd1};
                    reg_idx_next = issue_k;
                end
                default: begin
                    opcode_next = {4'b0000, issue_k, 4'b0101, issue_k - 4'd2};
                    reg_idx_next = issue_k;
                    push_valid = 1'b1;
                    push_exp   = e1_reg + e2_reg;
                    e1_next    = e1_reg + e2_reg;
                    e2_next    = e1_reg;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            k_reg         <= 4'd0;
            issued_reg    <= 1'b0;
            drain_reg     <= 3'd0;
            opcode_reg    <= 16'h0000;
            op_valid_reg  <= 1'b0;
            reg_idx_reg   <= 4'd0;
            e1_reg        <= '0;
            e2_reg        <= '0;
            cin_reg       <= 1'b0;
            err_reg       <= 1'b0;
            err_count_reg <= 8'd0;
            for (int i = 0; i <= CHECK_LAT; i++) begin
                pipe_valid_reg[i] <= 1'b0;
                pipe_exp_reg[i]   <= '0;
            end
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            issued_reg    <= issued_next;
            drain_reg     <= drain_next;
            opcode_reg    <= opcode_next;
            op_valid_reg  <= op_valid_next;
            reg_idx_reg   <= reg_idx_next;
            e1_reg        <= e1_next;
            e2_reg        <= e2_next;
            cin_reg       <= dp.flags[3];
            pipe_valid_reg[0] <= push_valid;
            pipe_exp_reg[0]   <= push_exp;
            for (int i = 1; i <= CHECK_LAT; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_exp_reg[i]   <= pipe_exp_reg[i-1];
            end
            if (restart) begin
                err_reg       <= 1'b0;
                err_count_reg <= 8'd0;
            end else if (mismatch) begin
                err_reg <= 1'b1;
                if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    assign dp.opcode   = opcode_reg;
    assign dp.op_valid = op_valid_reg;
    assign dp.cin      = cin_reg;
    assign state       = state_reg;
    assign reg_idx     = reg_idx_reg;
    assign busy        = (state_reg != IDLE) && (state_reg != DONE);
    assign done        = (state_reg == DONE);
    assign err         = err_reg;
    assign err_count   = err_count_reg;
endmodule

// File: tb/tb_regfile_fib_sequencer.sv
// Two sequencers (16-bit/latency 1 and 8-bit/latency 2) driving behavioural datapaths,
// with a queue scoreboard of the expected instruction trace.
module tb_regfile_fib_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, step_mode, step;
    logic [2:0] state_a, state_b;
    logic [3:0] idx_a, idx_b;
    logic busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [7:0] ec_a, ec_b;

    regfile_fib_sequencer_if #(.DATA_W(16)) ifa ();
    regfile_fib_sequencer_if #(.DATA_W(8))  ifb ();

    regfile_fib_sequencer #(.DATA_W(16), .NUM_REGS(16), .CHECK_LAT(1)) dut_a (
        .clk(clk), .reset(rst_n), .start(start), .step_mode(step_mode), .step(step),
        .dp(ifa), .state(state_a), .reg_idx(idx_a), .busy(busy_a), .done(done_a),
        .err(err_a), .err_count(ec_a));

    regfile_fib_sequencer #(.DATA_W(8), .NUM_REGS(16), .CHECK_LAT(2)) dut_b (
        .clk(clk), .reset(rst_n), .start(start), .step_mode(step_mode), .step(step),
        .dp(ifb), .state(state_b), .reg_idx(idx_b), .busy(busy_b), .done(done_b),
        .err(err_b), .err_count(ec_b));

    int checks = 0;
    int errors = 0;
    int vcnt_a = 0;
    int corrupt_reg = -1;
    logic cin_b_seen = 1'b0;
    logic [19:0] q_a[$];
    logic [19:0] q_b[$];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ---------------- behavioural datapath ----------------
    logic [15:0] rf_a [16];
    logic [15:0] rf_b [16];
    logic [15:0] st_a = '0, st_b0 = '0, st_b1 = '0;
    logic        c_a = 1'b0, c_b0 = 1'b0, c_b1 = 1'b0;
    logic [16:0] ra, rb;

    function automatic logic [16:0] exec_op(input logic [15:0] op, input logic [15:0] rd_v,
                                            input logic [15:0] rs_v, input int w);
        int s;
        logic c;
        if (op[15:12] == 4'b0101)     s = int'(op[7:0]);
        else if (op[7:4] == 4'b1101)  s = int'(rs_v);
        else                          s = int'(rd_v) + int'(rs_v);
        c = ((s >> w) & 1) != 0;
        return {c, 16'(s & ((1 << w) - 1))};
    endfunction

    assign ra = exec_op(ifa.opcode, rf_a[ifa.opcode[11:8]], rf_a[ifa.opcode[3:0]], 16);
    assign rb = exec_op(ifb.opcode, rf_b[ifb.opcode[11:8]], rf_b[ifb.opcode[3:0]], 8);

    always @(posedge clk) begin
        if (ifa.op_valid) begin
            rf_a[ifa.opcode[11:8]] <= ra[15:0];
            c_a  <= ra[16];
            st_a <= ra[15:0] + (((corrupt_reg == int'(ifa.opcode[11:8])) &&
                                 (ifa.opcode[15:12] == 4'b0000) && (ifa.opcode[7:4] == 4'b0101)) ? 16'd1 : 16'd0);
        end
        if (ifb.op_valid) begin
            rf_b[ifb.opcode[11:8]] <= rb[15:0];
            st_b0 <= rb[15:0];
            c_b0  <= rb[16];
        end
        st_b1 <= st_b0;
        c_b1  <= c_b0;
    end

    assign ifa.rout  = st_a;
    assign ifa.flags = {1'b0, c_a, 3'b000};
    assign ifb.rout  = st_b1[7:0];
    assign ifb.flags = {1'b0, c_b1, 3'b000};

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (ifa.op_valid) begin
            vcnt_a++;
            if (q_a.size() == 0) check_eq("unexpected_op_a", {idx_a, ifa.opcode}, 20'hFFFFF);
            else begin
                check_eq("op_trace_a", {idx_a, ifa.opcode}, q_a[0]);
                void'(q_a.pop_front());
            end
        end
        if (ifb.op_valid) begin
            if (q_b.size() == 0) check_eq("unexpected_op_b", {idx_b, ifb.opcode}, 20'hFFFFF);
            else begin
                check_eq("op_trace_b", {idx_b, ifb.opcode}, q_b[0]);
                void'(q_b.pop_front());
            end
        end
    end

    logic f3a_prev = 1'b0, f3b_prev = 1'b0, rst_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n && rst_prev) begin
            check_eq("cin_a", ifa.cin, f3a_prev);
            check_eq("cin_b", ifb.cin, f3b_prev);
        end
        if (ifb.cin) cin_b_seen = 1'b1;
        f3a_prev = ifa.flags[3];
        f3b_prev = ifb.flags[3];
        rst_prev = rst_n;
    end

    // ---------------- reference model ----------------
    function automatic int fib(input int n);
        int a = 1, b = 1, t;
        for (int i = 3; i <= n; i++) begin t = a + b; a = b; b = t; end
        return b;
    endfunction

    task automatic push_op(input logic [19:0] e);
        q_a.push_back(e);
        q_b.push_back(e);
    endtask

    task automatic push_trace();
        logic [3:0] k4, km1, km2;
        push_op({4'd0, 4'b0101, 4'd0, 8'h01});
        push_op({4'd1, 4'b0101, 4'd1, 8'h01});
        push_op({4'd1, 4'b0000, 4'd1, 4'b0101, 4'd0});
        for (int k = 2; k < 16; k++) begin
            k4 = 4'(k); km1 = 4'(k - 1); km2 = 4'(k - 2);
            push_op({k4, 4'b0000, k4, 4'b1101, km1});
            push_op({k4, 4'b0000, k4, 4'b0101, km2});
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!(done_a && done_b) && n < bound) begin @(negedge clk); n++; end
        check_eq({tag, "_done"}, {31'd0, done_a && done_b}, 32'd1);
    endtask

    task automatic after_sweep(input string tag, input int exp_ec_a);
        check_eq({tag, "_qa_left"}, q_a.size(), 0);
        check_eq({tag, "_qb_left"}, q_b.size(), 0);
        check_eq({tag, "_err_a"}, err_a, (exp_ec_a != 0) ? 1 : 0);
        check_eq({tag, "_errcnt_a"}, ec_a, exp_ec_a);
        check_eq({tag, "_err_b"}, err_b, 0);
        check_eq({tag, "_errcnt_b"}, ec_b, 0);
        check_eq({tag, "_r0_a"}, rf_a[0], 1);
        check_eq({tag, "_r15_a"}, rf_a[15], fib(17) & 16'hFFFF);
        check_eq({tag, "_r12_b"}, rf_b[12], fib(14) & 8'hFF);
        check_eq({tag, "_r15_b"}, rf_b[15], fib(17) & 8'hFF);
        check_eq({tag, "_busy_a"}, busy_a, 0);
        check_eq({tag, "_state_b"}, state_b, 6);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_state_a"}, state_a, 0);
        check_eq({tag, "_opcode_a"}, ifa.opcode, 16'h0000);
        check_eq({tag, "_flags_a"}, {ifa.op_valid, ifa.cin, busy_a, done_a, err_a}, 0);
        check_eq({tag, "_cnt_idx_a"}, {ec_a, idx_a}, 0);
        check_eq({tag, "_state_b"}, state_b, 0);
        check_eq({tag, "_opcode_b"}, ifb.opcode, 16'h0000);
        check_eq({tag, "_flags_b"}, {ifb.op_valid, ifb.cin, busy_b, done_b, err_b}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, base, gap;
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        #2;
        check_reset_vals("rst0");
        repeat (3) @(negedge clk);
        check_reset_vals("rst1");
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_nop", ifa.opcode, 16'h0FDF);

        // free-run sweep
        push_trace(); pulse_start(); wait_done("run1", 200);
        after_sweep("run1", 0);
        check_eq("run1_cin_b_seen", cin_b_seen, 1);
        check_eq("run1_valid_count", vcnt_a, 31);

        // corrupted r7 result on the 16-bit datapath
        corrupt_reg = 7;
        push_trace(); pulse_start(); wait_done("run2", 200);
        corrupt_reg = -1;
        after_sweep("run2", 1);

        // restart clears errors; start while busy is ignored
        push_trace(); pulse_start();
        check_eq("restart_err_a", {err_a, ec_a}, 0);
        repeat ($urandom_range(2, 20)) @(negedge clk);
        check_eq("busy_before_start", busy_a, 1);
        pulse_start();
        wait_done("run3", 200);
        after_sweep("run3", 0);

        // single-step
        step_mode = 1'b1;
        push_trace(); pulse_start();
        base = vcnt_a;
        repeat (3) @(negedge clk);
        check_eq("step_pending_state", state_a, 1);
        check_eq("step_pending_cnt", vcnt_a, base);
        for (int p = 1; p <= 5; p++) begin
            gap = $urandom_range(1, 3);
            repeat (gap) @(negedge clk);
            step = 1'b1;
            @(negedge clk); step = 1'b0;
            @(negedge clk);
            check_eq("step_one_valid", vcnt_a, base + p);
            check_eq("step_gap_nop", {ifa.op_valid, ifa.opcode}, {1'b0, 16'h0FDF});
        end
        check_eq("step5_state", state_a, 5);
        check_eq("step5_idx", idx_a, 2);
        check_eq("step5_state_b", {state_b, idx_b}, {3'd5, 4'd2});
        n = 0;
        while (!(done_a && done_b) && n < 2000) begin
            step_mode = 1'($urandom_range(0, 1));
            step      = 1'($urandom_range(0, 1));
            @(negedge clk); n++;
        end
        step_mode = 1'b0; step = 1'b0;
        wait_done("run4", 10);
        after_sweep("run4", 0);

        // asynchronous reset mid-sweep at MOV r9
        push_trace(); pulse_start();
        n = 0;
        while (!(state_a == 3'd4 && idx_a == 4'd9) && n < 100) begin @(negedge clk); n++; end
        check_eq("found_mov9", {state_a, idx_a}, {3'd4, 4'd9});
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        q_a.delete(); q_b.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        push_trace(); pulse_start(); wait_done("run5", 200);
        after_sweep("run5", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
